// File: rtl/display_pkg.sv
// Shared seven-segment glyphs (active-low, bit order g..a) and decoder state encoding.
package display_pkg;

    localparam int unsigned SEG_W = 7;
    localparam int unsigned CNT_W = 8;

    localparam logic [SEG_W-1:0] SEG_0     = 7'b1000000;
    localparam logic [SEG_W-1:0] SEG_1     = 7'b1111001;
    localparam logic [SEG_W-1:0] SEG_2     = 7'b0100100;
    localparam logic [SEG_W-1:0] SEG_3     = 7'b0110000;
    localparam logic [SEG_W-1:0] SEG_4     = 7'b0011001;
    localparam logic [SEG_W-1:0] SEG_5     = 7'b0010010;
    localparam logic [SEG_W-1:0] SEG_6     = 7'b0000010;
    localparam logic [SEG_W-1:0] SEG_7     = 7'b1111000;
    localparam logic [SEG_W-1:0] SEG_8     = 7'b0000000;
    localparam logic [SEG_W-1:0] SEG_9     = 7'b0011000;
    localparam logic [SEG_W-1:0] SEG_BLANK = 7'b1111111;

    typedef enum logic {FILTER, HOLD} state_t;

endpackage

// File: rtl/seg7_digit_decode.sv
// Maps one active-low seven-segment pattern back to a digit; valid_c covers glyphs 0-9 and blank.
module seg7_digit_decode
    import display_pkg::*;
(
    input  logic [6:0] seg,
    output logic [3:0] digit_c,
    output logic       blank_c,
    output logic       valid_c
);

    always_comb begin
        digit_c = 4'd0;
        blank_c = 1'b0;
        valid_c = 1'b1;
        case (seg)
            SEG_0:     digit_c = 4'd0;
            SEG_1:     digit_c = 4'd1;
            SEG_2:     digit_c = 4'd2;
            SEG_3:     digit_c = 4'd3;
            SEG_4:     digit_c = 4'd4;
            SEG_5:     digit_c = 4'd5;
            SEG_6:     digit_c = 4'd6;
            SEG_7:     digit_c = 4'd7;
            SEG_8:     digit_c = 4'd8;
            SEG_9:     digit_c = 4'd9;
            SEG_BLANK: blank_c = 1'b1;
            default:   valid_c = 1'b0;
        endcase
    end

endmodule

// File: rtl/display_decoder.sv
// Glitch-filtered two-digit seven-segment reader with valid/ready output.
// Optional DISPLAY_DECODER_OVERRUN_EN keeps filtering during HOLD and adds a sticky overrun flag.
module display_decoder
    import display_pkg::*;
#(
    parameter int unsigned STABLE_CYCLES = 4
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [13:0] display,
    output logic [3:0]  value,
    output logic        value_valid,
    input  logic        value_ready,
    output logic        error
`ifdef DISPLAY_DECODER_OVERRUN_EN
    ,
    output logic        overrun
`endif
);

    localparam int unsigned DISP_W = 14;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CYCLES - 1);

    logic [DISP_W-1:0] disp_q;
    logic              disp_vld;
    logic [DISP_W-1:0] cand;
    logic              cand_vld;
    logic [CNT_W-1:0]  count;
    logic [DISP_W-1:0] last_acc;
    logic              last_vld;
    state_t            state;

    logic [3:0] units_digit_c, tens_digit_c;
    logic       units_blank_c, tens_blank_c;
    logic       units_valid_c, tens_valid_c;
    logic [4:0] result_c;
    logic       dec_ok_c;
    logic       filter_en_c;
    logic       accept_c;

    seg7_digit_decode u_units (
        .seg     (cand[13:7]),
        .digit_c (units_digit_c),
        .blank_c (units_blank_c),
        .valid_c (units_valid_c)
    );

    seg7_digit_decode u_tens (
        .seg     (cand[6:0]),
        .digit_c (tens_digit_c),
        .blank_c (tens_blank_c),
        .valid_c (tens_valid_c)
    );

    // Units must be a real digit; tens may only be blank (0) or one.
    always_comb begin
        result_c = 5'(units_digit_c) + (tens_blank_c ? 5'd0 : 5'd10);
        dec_ok_c = units_valid_c && !units_blank_c && tens_valid_c
                   && (tens_blank_c || tens_digit_c == 4'd1)
                   && result_c <= 5'd15;
    end

`ifdef DISPLAY_DECODER_OVERRUN_EN
    assign filter_en_c = 1'b1;
`else
    assign filter_en_c = (state == FILTER);
`endif

    assign accept_c = filter_en_c && cand_vld && (count == CNT_MAX)
                      && (!last_vld || cand != last_acc);

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            disp_q      <= '1;
            disp_vld    <= 1'b0;
            cand        <= '1;
            cand_vld    <= 1'b0;
            count       <= '0;
            last_acc    <= '1;
            last_vld    <= 1'b0;
            state       <= FILTER;
            value       <= 4'd0;
            value_valid <= 1'b0;
            error       <= 1'b0;
`ifdef DISPLAY_DECODER_OVERRUN_EN
            overrun     <= 1'b0;
`endif
        end else begin
            disp_q   <= display;
            disp_vld <= 1'b1;
            error    <= 1'b0;

            if (filter_en_c) begin
                if (disp_vld && (!cand_vld || disp_q != cand)) begin
                    cand     <= disp_q;
                    cand_vld <= 1'b1;
                    count    <= '0;
                end else if (cand_vld && count != CNT_MAX) begin
                    count <= count + CNT_W'(1);
                end
            end

            // Every accepted pattern is remembered, decodable or not, so it is judged once.
            if (accept_c) begin
                last_acc <= cand;
                last_vld <= 1'b1;
                if (dec_ok_c) value <= result_c[3:0];
                else          error <= 1'b1;
            end

            case (state)
                FILTER: begin
                    if (accept_c && dec_ok_c) begin
                        state       <= HOLD;
                        value_valid <= 1'b1;
                    end
                end
                HOLD: begin
`ifdef DISPLAY_DECODER_OVERRUN_EN
                    if (accept_c && dec_ok_c) begin
                        if (!value_ready) overrun <= 1'b1;
                    end else if (value_ready) begin
                        state       <= FILTER;
                        value_valid <= 1'b0;
                        count       <= '0;
                    end
`else
                    if (value_ready) begin
                        state       <= FILTER;
                        value_valid <= 1'b0;
                        count       <= '0;
                    end
`endif
                end
                default: state <= FILTER;
            endcase
        end
    end

endmodule
